// File: rtl/scalar_ladder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scalar_ladder_ctrl_pkg
//   Shared constants for the scalar-multiply ladder controller:
//   - default scalar width and key_cnt width
//   - key_state encodings reported by the key scanner
//   - FSM state encodings for scalar_ladder_ctrl (also exposed on dbg_state)
// -----------------------------------------------------------------------------
package scalar_ladder_ctrl_pkg;

  localparam int N_DEFAULT  = 233;
  localparam int CW_DEFAULT = 8;

  // key_state encodings from the scanner
  localparam logic [1:0] KEY_NORMAL  = 2'b00;
  localparam logic [1:0] KEY_IS_ZERO = 2'b01;
  localparam logic [1:0] KEY_IS_ONE  = 2'b11;

  // FSM state encodings
  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_IDLE        = 4'd0;
  localparam logic [ST_W-1:0] ST_CHECK       = 4'd1;
  localparam logic [ST_W-1:0] ST_JUDGE0      = 4'd2;
  localparam logic [ST_W-1:0] ST_JUDGE1      = 4'd3;
  localparam logic [ST_W-1:0] ST_JUDGE2      = 4'd4;
  localparam logic [ST_W-1:0] ST_FIND_WAIT   = 4'd5;
  localparam logic [ST_W-1:0] ST_INIT_WAIT   = 4'd6;
  localparam logic [ST_W-1:0] ST_SCAN_W1     = 4'd7;
  localparam logic [ST_W-1:0] ST_SCAN_W2     = 4'd8;
  localparam logic [ST_W-1:0] ST_SCAN_SAMPLE = 4'd9;
  localparam logic [ST_W-1:0] ST_STEP_WAIT   = 4'd10;

endpackage

// File: rtl/scalar_ladder_ctrl_if.sv
// -----------------------------------------------------------------------------
// scalar_ladder_ctrl_if
//   Bundles the command, key-scanner and ladder-datapath signals of the
//   scalar ladder controller.
//
//   Handshake semantics: every strobe here (start, key_load, key_check,
//   keyfind_en, keyscan_en, ladder_init_start, ladder_step_start,
//   ladder_done, done) is a single-cycle pulse sampled on the rising clock
//   edge; there is no back-pressure. A pulse is consumed in the cycle it is
//   high or is dropped if the receiver is not waiting for it. Levels
//   (key_state, key_first_found, ki, key_cnt, ladder_bit, busy, res_inf,
//   res_p) are valid whenever the owner's protocol says so and are held
//   otherwise.
//
//   master : the controller (scalar_ladder_ctrl)
//   slave  : the environment (command source, key scanner, ladder datapath)
// -----------------------------------------------------------------------------
interface scalar_ladder_ctrl_if
  import scalar_ladder_ctrl_pkg::*;
#(
  parameter int CW = CW_DEFAULT
);
  // command side
  logic          start;
  logic          busy;
  logic          done;
  logic          res_inf;
  logic          res_p;
  // key scanner side
  logic          key_load;
  logic          key_check;
  logic          keyfind_en;
  logic          keyscan_en;
  logic [1:0]    key_state;
  logic          key_first_found;
  logic          ki;
  logic [CW-1:0] key_cnt;
  // ladder datapath side
  logic          ladder_init_start;
  logic          ladder_step_start;
  logic          ladder_bit;
  logic          ladder_done;

  modport master (
    input  start, key_state, key_first_found, ki, key_cnt, ladder_done,
    output busy, done, res_inf, res_p,
    output key_load, key_check, keyfind_en, keyscan_en,
    output ladder_init_start, ladder_step_start, ladder_bit
  );

  modport slave (
    output start, key_state, key_first_found, ki, key_cnt, ladder_done,
    input  busy, done, res_inf, res_p,
    input  key_load, key_check, keyfind_en, keyscan_en,
    input  ladder_init_start, ladder_step_start, ladder_bit
  );

endinterface

// File: rtl/scalar_ladder_ctrl_ladder_cmd_pulse.sv
// -----------------------------------------------------------------------------
// ladder_cmd_pulse
//   Registered single-cycle strobe generator for the ladder datapath, plus
//   the ladder_bit hold register. ladder_bit is captured together with the
//   step strobe and held until the next step is issued, so it stays stable
//   for the whole datapath operation.
//
//   Ports:
//     CLK, RST          clock, asynchronous active-high reset
//     fire_init         request an init strobe next cycle
//     fire_step         request a step strobe next cycle
//     bit_in            scalar bit to present with the step
//     init_start        registered ladder_init_start pulse
//     step_start        registered ladder_step_start pulse
//     ladder_bit        held scalar bit for the current step
// -----------------------------------------------------------------------------
module ladder_cmd_pulse (
  input  logic CLK,
  input  logic RST,
  input  logic fire_init,
  input  logic fire_step,
  input  logic bit_in,
  output logic init_start,
  output logic step_start,
  output logic ladder_bit
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      init_start <= 1'b0;
      step_start <= 1'b0;
      ladder_bit <= 1'b0;
    end else begin
      init_start <= fire_init;
      step_start <= fire_step;
      if (fire_step) begin
        ladder_bit <= bit_in;
      end
    end
  end

endmodule

// File: rtl/scalar_ladder_ctrl.sv
// -----------------------------------------------------------------------------
// scalar_ladder_ctrl
//   Sequences one Montgomery-ladder scalar multiply: loads and classifies the
//   scalar through the key scanner, searches for the leading one, issues the
//   ladder init, then one ladder step per remaining scalar bit. Scalars 0 and
//   1 finish without any point operation and are flagged via res_inf/res_p.
//
//   Ports:
//     CLK        system clock (rising edge)
//     RST        asynchronous active-high reset; aborts any operation
//     bus        scalar_ladder_ctrl_if.master (command, scanner, datapath)
//     dbg_state  current FSM state (encodings in scalar_ladder_ctrl_pkg)
// -----------------------------------------------------------------------------
module scalar_ladder_ctrl
  import scalar_ladder_ctrl_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  scalar_ladder_ctrl_if.master bus,
  output logic [ST_W-1:0]    dbg_state
);

  // key_cnt reaching N means every scalar bit has been consumed
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;

  logic key_load_q;
  logic key_check_q;
  logic keyfind_q;
  logic keyscan_q;
  logic done_q;
  logic busy_q;
  logic res_inf_q;
  logic res_p_q;

  logic accept;
  logic judge_zero;
  logic judge_one;
  logic judge_norm;
  logic op_done;
  logic all_bits;
  logic fire_init;
  logic fire_step;
  logic finish;

  // start is only honoured in IDLE, which also makes it win over any
  // stray ladder_done arriving in the same cycle
  assign accept     = (state_q == ST_IDLE) && bus.start;
  assign judge_zero = (state_q == ST_JUDGE2) && (bus.key_state == KEY_IS_ZERO);
  assign judge_one  = (state_q == ST_JUDGE2) && (bus.key_state == KEY_IS_ONE);
  // any other key_state code is treated as an ordinary scalar
  assign judge_norm = (state_q == ST_JUDGE2) && !judge_zero && !judge_one;
  // ladder_done only counts while a datapath op is outstanding
  assign op_done    = ((state_q == ST_INIT_WAIT) || (state_q == ST_STEP_WAIT))
                      && bus.ladder_done;
  assign all_bits   = (bus.key_cnt == N_CNT);
  assign fire_init  = (state_q == ST_FIND_WAIT) && bus.key_first_found;
  // the scanner needs one cycle to leave idle and one to register ki, so ki
  // is sampled in the third cycle after the scan request
  assign fire_step  = (state_q == ST_SCAN_SAMPLE);
  assign finish     = judge_zero || judge_one || (op_done && all_bits);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (accept) state_d = ST_CHECK;
      ST_CHECK:       state_d = ST_JUDGE0;
      ST_JUDGE0:      state_d = ST_JUDGE1;
      ST_JUDGE1:      state_d = ST_JUDGE2;
      ST_JUDGE2:      state_d = judge_norm ? ST_FIND_WAIT : ST_IDLE;
      ST_FIND_WAIT:   if (bus.key_first_found) state_d = ST_INIT_WAIT;
      ST_INIT_WAIT,
      ST_STEP_WAIT:   if (bus.ladder_done) state_d = all_bits ? ST_IDLE : ST_SCAN_W1;
      ST_SCAN_W1:     state_d = ST_SCAN_W2;
      ST_SCAN_W2:     state_d = ST_SCAN_SAMPLE;
      ST_SCAN_SAMPLE: state_d = ST_STEP_WAIT;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      key_load_q  <= 1'b0;
      key_check_q <= 1'b0;
      keyfind_q   <= 1'b0;
      keyscan_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      res_inf_q   <= 1'b0;
      res_p_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_load_q  <= accept;
      key_check_q <= (state_q == ST_CHECK);
      keyfind_q   <= judge_norm;
      // next scan request lands the cycle after ladder_done at the earliest
      keyscan_q   <= op_done && !all_bits;
      done_q      <= finish;

      if (accept) begin
        busy_q <= 1'b1;
      end else if (finish) begin
        busy_q <= 1'b0;
      end

      if (accept) begin
        res_inf_q <= 1'b0;
        res_p_q   <= 1'b0;
      end else begin
        if (judge_zero) res_inf_q <= 1'b1;
        if (judge_one)  res_p_q   <= 1'b1;
      end
    end
  end

  logic init_start_w;
  logic step_start_w;
  logic ladder_bit_w;

  ladder_cmd_pulse u_cmd (
    .CLK        (CLK),
    .RST        (RST),
    .fire_init  (fire_init),
    .fire_step  (fire_step),
    .bit_in     (bus.ki),
    .init_start (init_start_w),
    .step_start (step_start_w),
    .ladder_bit (ladder_bit_w)
  );

  assign bus.key_load          = key_load_q;
  assign bus.key_check         = key_check_q;
  assign bus.keyfind_en        = keyfind_q;
  assign bus.keyscan_en        = keyscan_q;
  assign bus.done              = done_q;
  assign bus.busy              = busy_q;
  assign bus.res_inf           = res_inf_q;
  assign bus.res_p             = res_p_q;
  assign bus.ladder_init_start = init_start_w;
  assign bus.ladder_step_start = step_start_w;
  assign bus.ladder_bit        = ladder_bit_w;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_scalar_ladder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scalar_ladder_ctrl
//   Drives scalar_ladder_ctrl with a behavioural key scanner and ladder
//   datapath, checks each operation against a reference computed from the
//   scalar value (leading-one position and the bits below it).
// -----------------------------------------------------------------------------
module tb_scalar_ladder_ctrl;
  import scalar_ladder_ctrl_pkg::*;

  localparam int N  = 233;
  localparam int CW = 8;
  localparam logic [N-1:0] K_ONE = {{(N-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------- clock/reset
  logic            CLK = 1'b0;
  logic            RST;
  logic [ST_W-1:0] dbg_state;

  always #5 CLK = ~CLK;

  scalar_ladder_ctrl_if #(.CW(CW)) bus ();

  scalar_ladder_ctrl #(.N(N), .CW(CW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // scoreboard of expected ladder bits, MSB first
  logic [0:0] exp_q[$];

  // environment model state
  logic [N-1:0] cur_k;
  logic [N-1:0] mk;
  int  m_cnt, scan_dly, dp_cnt, dp_lat;
  bit  m_finding, inject_spur, dp_is_step, held_bit;
  int  n_load, n_check, n_find, n_scan, n_init, n_step, n_done;
  int  cyc = 0, t_load, t_check, t_done;
  int  last_inf, last_p;

  task automatic clear_counts();
    n_load = 0; n_check = 0; n_find = 0; n_scan = 0;
    n_init = 0; n_step = 0; n_done = 0;
    t_load = 0; t_check = 0; t_done = 0;
  endtask

  // Reference: leading-one position decides the outcome; bits below it
  // are the ladder bits in MSB-first order.
  function automatic void ref_model(input logic [N-1:0] k, output bit inf,
                                    output bit p, output int steps);
    int top;
    top = -1;
    exp_q.delete();
    for (int i = 0; i < N; i++) if (k[i]) top = i;
    inf   = (top < 0);
    p     = (top == 0);
    steps = (top > 0) ? top : 0;
    for (int i = top - 1; i >= 0; i--) exp_q.push_back(k[i]);
  endfunction

  // ------------------------------------------- scanner + datapath + monitor
  always @(negedge CLK) begin
    logic [6:0] strobes;
    cyc++;
    if (RST) begin
      bus.key_state = KEY_NORMAL; bus.key_first_found = 1'b0; bus.ki = 1'b0;
      bus.key_cnt = '0; bus.ladder_done = 1'b0;
      m_finding = 0; scan_dly = 0; dp_cnt = 0; m_cnt = 0;
    end else begin
      strobes = {bus.key_load, bus.key_check, bus.keyfind_en, bus.keyscan_en,
                 bus.ladder_init_start, bus.ladder_step_start, bus.done};
      if (strobes != 7'd0) check("single_strobe", $countones(strobes), 1);

      if (bus.key_load) begin
        n_load++; t_load = cyc;
        mk = cur_k; m_cnt = 0; m_finding = 0; scan_dly = 0;
        bus.key_cnt = '0; bus.key_first_found = 1'b0; bus.ki = 1'b0;
        bus.key_state = KEY_NORMAL;
      end
      if (bus.key_check) begin
        n_check++; t_check = cyc;
        bus.key_state = (mk == '0) ? KEY_IS_ZERO : (mk == K_ONE) ? KEY_IS_ONE : KEY_NORMAL;
      end

      // leading-one search, one bit per cycle from the MSB
      if (m_finding) begin
        if (m_cnt >= N) m_finding = 0;
        else begin
          bus.key_first_found = mk[N-1-m_cnt];
          m_cnt++;
          bus.key_cnt = CW'(m_cnt);
          if (bus.key_first_found) m_finding = 0;
        end
      end
      if (bus.keyfind_en) begin n_find++; m_finding = 1; end

      // scan: ki registered two cycles after the request
      if (scan_dly > 0) begin
        scan_dly--;
        if (scan_dly == 0 && m_cnt < N) begin
          bus.ki = mk[N-1-m_cnt];
          m_cnt++;
          bus.key_cnt = CW'(m_cnt);
        end
      end
      if (bus.keyscan_en) begin n_scan++; scan_dly = 2; end

      // datapath: ladder_done dp_lat cycles after each start
      bus.ladder_done = 1'b0;
      if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          bus.ladder_done = 1'b1;
          if (dp_is_step) check("ladder_bit_hold", int'(bus.ladder_bit), int'(held_bit));
        end
      end
      if (inject_spur && bus.keyscan_en) bus.ladder_done = 1'b1;
      if (bus.ladder_init_start) begin n_init++; dp_cnt = dp_lat; dp_is_step = 0; end
      if (bus.ladder_step_start) begin
        n_step++; dp_cnt = dp_lat; dp_is_step = 1; held_bit = bus.ladder_bit;
        check("step_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("ladder_bit", int'(bus.ladder_bit), int'(exp_q.pop_front()));
      end
      if (bus.done) begin
        n_done++; t_done = cyc;
        last_inf = int'(bus.res_inf); last_p = int'(bus.res_p);
        check("busy_low_at_done", int'(bus.busy), 0);
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic pulse_start();
    @(negedge CLK); bus.start = 1'b1;
    @(negedge CLK); bus.start = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] k, input int lat, input bit spur,
                        input bit restart, input bit e_inf, input bit e_p,
                        input int e_steps);
    bit m_inf, m_p, seen;
    int m_steps;
    cur_k = k; dp_lat = lat; inject_spur = spur;
    ref_model(k, m_inf, m_p, m_steps);
    clear_counts();
    pulse_start();
    if (restart) begin
      fork
        begin
          repeat (3) begin
            repeat (6) @(negedge CLK);
            bus.start = 1'b1;
            @(negedge CLK);
            bus.start = 1'b0;
          end
        end
      join_none
    end
    seen = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge CLK); #1;
      if (n_done != 0) begin seen = 1; break; end
    end
    check("done_seen", int'(seen), 1);
    repeat (30) @(negedge CLK);
    #1;
    check("key_load_cnt", n_load, 1);
    check("key_check_cnt", n_check, 1);
    check("key_check_lat", t_check - t_load, 1);
    check("done_cnt", n_done, 1);
    check("res_inf", last_inf, int'(e_inf));
    check("res_p", last_p, int'(e_p));
    check("res_inf_held", int'(bus.res_inf), int'(e_inf));
    check("res_p_held", int'(bus.res_p), int'(e_p));
    check("keyfind_cnt", n_find, (e_inf || e_p) ? 0 : 1);
    check("init_cnt", n_init, (e_inf || e_p) ? 0 : 1);
    check("step_cnt", n_step, e_steps);
    check("scan_cnt", n_scan, e_steps);
    check("bits_left", exp_q.size(), 0);
    check("busy_after", int'(bus.busy), 0);
    if (e_inf || e_p) check("done_lat", t_done - t_load, 4);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [N-1:0] k;
    int           lat;
    bit           e_inf;
    bit           e_p;
    int           e_steps;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [N-1:0] k;
    bit m_inf, m_p, seen;
    int m_steps, msb;

    vecs[0] = '{k: '0,    lat: 3, e_inf: 1, e_p: 0, e_steps: 0};
    vecs[1] = '{k: K_ONE, lat: 3, e_inf: 0, e_p: 1, e_steps: 0};
    k = '0; k[232] = 1'b1;
    vecs[2] = '{k: k,     lat: 3, e_inf: 0, e_p: 0, e_steps: 232};
    k = '0; k[3:0] = 4'b1011;
    vecs[3] = '{k: k,     lat: 3, e_inf: 0, e_p: 0, e_steps: 3};
    k = '0; k[1] = 1'b1;
    vecs[4] = '{k: k,     lat: 1, e_inf: 0, e_p: 0, e_steps: 1};
    k = '0; k[1:0] = 2'b11;
    vecs[5] = '{k: k,     lat: 4, e_inf: 0, e_p: 0, e_steps: 1};
    k = '0; k[232] = 1'b1; k[0] = 1'b1;
    vecs[6] = '{k: k,     lat: 2, e_inf: 0, e_p: 0, e_steps: 232};

    // reset state
    bus.start = 1'b0; inject_spur = 0; dp_lat = 3; cur_k = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("reset_outputs", int'({bus.key_load, bus.key_check, bus.keyfind_en, bus.keyscan_en,
          bus.ladder_init_start, bus.ladder_step_start, bus.ladder_bit,
          bus.busy, bus.done, bus.res_inf, bus.res_p}), 0);
    @(negedge CLK); RST = 1'b0;
    repeat (2) @(negedge CLK);

    // table-driven directed operations
    foreach (vecs[i]) begin
      run_op(vecs[i].k, vecs[i].lat, 1'b0, 1'b0, vecs[i].e_inf, vecs[i].e_p, vecs[i].e_steps);
    end

    // reset in the middle of the ladder steps
    k = '0; k[232] = 1'b1;
    cur_k = k; dp_lat = 3; inject_spur = 0;
    ref_model(k, m_inf, m_p, m_steps);
    clear_counts();
    pulse_start();
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK); #1;
      if (n_step >= 2) begin seen = 1; break; end
    end
    check("reached_step_wait", int'(seen), 1);
    @(posedge CLK); #2;
    RST = 1'b1;
    #1;
    check("async_reset_outputs", int'({bus.key_load, bus.key_check, bus.keyfind_en, bus.keyscan_en,
          bus.ladder_init_start, bus.ladder_step_start, bus.ladder_bit,
          bus.busy, bus.done, bus.res_inf, bus.res_p}), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    clear_counts();
    repeat (10) @(negedge CLK);
    #1;
    check("no_done_after_abort", n_done, 0);
    k = '0; k[3:0] = 4'b1011;
    run_op(k, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // restart pulses while busy plus spurious ladder_done during scans
    run_op(k, 3, 1'b1, 1'b1, 1'b0, 1'b0, 3);

    // randomized scalars against the reference model
    for (int r = 0; r < 6; r++) begin
      msb = $urandom_range(2, 120);
      k = '0;
      k[msb] = 1'b1;
      for (int j = 0; j < msb; j++) k[j] = 1'($urandom_range(0, 1));
      ref_model(k, m_inf, m_p, m_steps);
      run_op(k, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b0, m_inf, m_p, m_steps);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
